// File: rtl/empty_ptr_alloc.sv
// empty_ptr_alloc: hands out free pointers from an external show-ahead storage queue and
// returns released pointers to it through a small return FIFO.
//
// Parameters
//   A_WIDTH      pointer width; the pool holds 2**A_WIDTH pointers
//   RET_DEPTH_W  log2 of the return-buffer depth
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   alloc_req_i              level request for one pointer
//   alloc_ptr_o/alloc_val_o  granted pointer and its one-cycle strobe
//   alloc_fail_o             one-cycle strobe: storage empty when requested
//   free_ptr_i/free_en_i     pointer release and its strobe
//   free_ready_o             return buffer not full
//   next_empty_ptr_i/_val_i  storage head (show-ahead) and its valid
//   next_empty_ptr_rd_ack_o  pop the storage head
//   add_empty_ptr_o/_en_o    pointer pushed back into storage
//   used_cnt_o               pointers granted and not yet released
//   dbl_free_o               one-cycle strobe: release of a pointer not in use
//
// Build option
//   EMPTY_PTR_DBL_FREE_CHK_EN  adds a per-pointer in-use map that drops and flags
//                              releases of pointers that are not currently granted.
module empty_ptr_alloc #(
    parameter int unsigned A_WIDTH     = 8,
    parameter int unsigned RET_DEPTH_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               alloc_req_i,
    output logic [A_WIDTH-1:0] alloc_ptr_o,
    output logic               alloc_val_o,
    output logic               alloc_fail_o,
    input  logic [A_WIDTH-1:0] free_ptr_i,
    input  logic               free_en_i,
    output logic               free_ready_o,
    input  logic [A_WIDTH-1:0] next_empty_ptr_i,
    input  logic               next_empty_ptr_val_i,
    output logic               next_empty_ptr_rd_ack_o,
    output logic [A_WIDTH-1:0] add_empty_ptr_o,
    output logic               add_empty_ptr_en_o,
    output logic [A_WIDTH:0]   used_cnt_o,
    output logic               dbl_free_o
);

    localparam int unsigned RetDepth = 1 << RET_DEPTH_W;
    localparam logic [RET_DEPTH_W:0]   RetFull = RetDepth[RET_DEPTH_W:0];
    localparam logic [RET_DEPTH_W:0]   CntOne  = 1;
    localparam logic [RET_DEPTH_W-1:0] IdxOne  = 1;
    localparam logic [A_WIDTH:0]       UsedOne = 1;

    typedef enum logic [1:0] {StInit, StIdle, StGrant} state_e;

    state_e                 state_q;
    logic [A_WIDTH-1:0]     alloc_ptr_q;
    logic                   alloc_val_q;
    logic                   alloc_fail_q;
    logic [A_WIDTH:0]       used_cnt_q;

    logic [A_WIDTH-1:0]     ret_mem_q [RetDepth];
    logic [RET_DEPTH_W-1:0] wr_idx_q;
    logic [RET_DEPTH_W-1:0] rd_idx_q;
    logic [RET_DEPTH_W:0]   ret_cnt_q;

    logic rd_ack;
    logic ret_full;
    logic ret_empty;
    logic free_hit;
    logic accept;
    logic drain;

    assign rd_ack    = (state_q == StIdle) && alloc_req_i && next_empty_ptr_val_i;
    assign ret_full  = (ret_cnt_q == RetFull);
    assign ret_empty = (ret_cnt_q == '0);
    // Gated with reset so every output reads 0 while rst_i is held.
    assign free_ready_o = ~ret_full & ~rst_i;
    assign free_hit     = free_en_i & free_ready_o;
    // Storage only receives pointers once it has signalled it is initialised.
    assign drain        = (state_q != StInit) && !ret_empty;

`ifdef EMPTY_PTR_DBL_FREE_CHK_EN
    localparam int unsigned PoolSize = 1 << A_WIDTH;

    logic [PoolSize-1:0] in_use_q;
    logic [PoolSize-1:0] in_use_d;
    logic                dbl_free_q;

    assign accept     = free_hit & in_use_q[free_ptr_i];
    assign dbl_free_o = dbl_free_q;

    always_comb begin
        in_use_d = in_use_q;
        if (accept) in_use_d[free_ptr_i] = 1'b0;
        if (rd_ack) in_use_d[next_empty_ptr_i] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_use_q   <= '0;
            dbl_free_q <= 1'b0;
        end else begin
            in_use_q   <= in_use_d;
            dbl_free_q <= free_hit & ~in_use_q[free_ptr_i];
        end
    end
`else
    assign accept     = free_hit;
    assign dbl_free_o = 1'b0;
`endif

    // Allocation FSM with registered grant/fail strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StInit;
            alloc_ptr_q  <= '0;
            alloc_val_q  <= 1'b0;
            alloc_fail_q <= 1'b0;
        end else begin
            alloc_val_q  <= 1'b0;
            alloc_fail_q <= 1'b0;
            unique case (state_q)
                StInit: begin
                    if (next_empty_ptr_val_i) state_q <= StIdle;
                end
                StIdle: begin
                    if (rd_ack) begin
                        alloc_ptr_q <= next_empty_ptr_i;
                        alloc_val_q <= 1'b1;
                        state_q     <= StGrant;
                    end else if (alloc_req_i) begin
                        alloc_fail_q <= 1'b1;
                    end
                end
                StGrant: state_q <= StIdle;
                default: state_q <= StInit;
            endcase
        end
    end

    // Return buffer bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            ret_cnt_q <= '0;
        end else begin
            if (accept) wr_idx_q <= wr_idx_q + IdxOne;
            if (drain)  rd_idx_q <= rd_idx_q + IdxOne;
            unique case ({accept, drain})
                2'b10:   ret_cnt_q <= ret_cnt_q + CntOne;
                2'b01:   ret_cnt_q <= ret_cnt_q - CntOne;
                default: ret_cnt_q <= ret_cnt_q;
            endcase
        end
    end

    // Storage array needs no reset: entries are only read behind ret_cnt_q.
    always_ff @(posedge clk_i) begin
        if (accept) ret_mem_q[wr_idx_q] <= free_ptr_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            used_cnt_q <= '0;
        end else begin
            unique case ({rd_ack, accept})
                2'b10:   used_cnt_q <= used_cnt_q + UsedOne;
                2'b01:   used_cnt_q <= used_cnt_q - UsedOne;
                default: used_cnt_q <= used_cnt_q;
            endcase
        end
    end

    assign alloc_ptr_o             = alloc_ptr_q;
    assign alloc_val_o             = alloc_val_q;
    assign alloc_fail_o            = alloc_fail_q;
    assign next_empty_ptr_rd_ack_o = rd_ack;
    assign add_empty_ptr_en_o      = drain;
    assign add_empty_ptr_o         = drain ? ret_mem_q[rd_idx_q] : '0;
    assign used_cnt_o              = used_cnt_q;

endmodule

// File: tb/tb_empty_ptr_alloc.sv
module tb_empty_ptr_alloc;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       alloc_req_i = 1'b0;
    logic [3:0] alloc_ptr_o;
    logic       alloc_val_o;
    logic       alloc_fail_o;
    logic [3:0] free_ptr_i = '0;
    logic       free_en_i = 1'b0;
    logic       free_ready_o;
    logic [3:0] next_empty_ptr_i = '0;
    logic       next_empty_ptr_val_i = 1'b0;
    logic       next_empty_ptr_rd_ack_o;
    logic [3:0] add_empty_ptr_o;
    logic       add_empty_ptr_en_o;
    logic [4:0] used_cnt_o;
    logic       dbl_free_o;

    int checks = 0;
    int errors = 0;

    empty_ptr_alloc #(
        .A_WIDTH    (4),
        .RET_DEPTH_W(2)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .alloc_req_i            (alloc_req_i),
        .alloc_ptr_o            (alloc_ptr_o),
        .alloc_val_o            (alloc_val_o),
        .alloc_fail_o           (alloc_fail_o),
        .free_ptr_i             (free_ptr_i),
        .free_en_i              (free_en_i),
        .free_ready_o           (free_ready_o),
        .next_empty_ptr_i       (next_empty_ptr_i),
        .next_empty_ptr_val_i   (next_empty_ptr_val_i),
        .next_empty_ptr_rd_ack_o(next_empty_ptr_rd_ack_o),
        .add_empty_ptr_o        (add_empty_ptr_o),
        .add_empty_ptr_en_o     (add_empty_ptr_en_o),
        .used_cnt_o             (used_cnt_o),
        .dbl_free_o             (dbl_free_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        alloc_req_i = 1'b0;
        free_en_i = 1'b0;
        free_ptr_i = '0;
        next_empty_ptr_i = '0;
        next_empty_ptr_val_i = 1'b0;
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #1;
        checks++; if (alloc_ptr_o !== 4'd0) begin errors++; $display("FAIL rst_alloc_ptr got %0h want 0", alloc_ptr_o); end
        checks++; if (alloc_val_o !== 1'b0) begin errors++; $display("FAIL rst_alloc_val got %0b want 0", alloc_val_o); end
        checks++; if (alloc_fail_o !== 1'b0) begin errors++; $display("FAIL rst_alloc_fail got %0b want 0", alloc_fail_o); end
        checks++; if (free_ready_o !== 1'b0) begin errors++; $display("FAIL rst_free_ready got %0b want 0", free_ready_o); end
        checks++; if (add_empty_ptr_en_o !== 1'b0) begin errors++; $display("FAIL rst_add_en got %0b want 0", add_empty_ptr_en_o); end
        checks++; if (used_cnt_o !== 5'd0) begin errors++; $display("FAIL rst_used_cnt got %0d want 0", used_cnt_o); end
        checks++; if (dbl_free_o !== 1'b0) begin errors++; $display("FAIL rst_dbl_free got %0b want 0", dbl_free_o); end
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if (free_ready_o !== 1'b1) begin errors++; $display("FAIL rel_free_ready got %0b want 1", free_ready_o); end
    endtask

    // Request held while storage is not yet valid: nothing happens until INIT exits.
    task automatic test_init_hold();
        do_reset();
        alloc_req_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++; if (next_empty_ptr_rd_ack_o !== 1'b0) begin errors++; $display("FAIL init_rd_ack cyc %0d got %0b want 0", i, next_empty_ptr_rd_ack_o); end
            tick();
            checks++; if ({alloc_val_o, alloc_fail_o} !== 2'b00) begin errors++; $display("FAIL init_strobe cyc %0d got %0b want 00", i, {alloc_val_o, alloc_fail_o}); end
        end
        next_empty_ptr_i = 4'hA;
        next_empty_ptr_val_i = 1'b1;
        #1;
        checks++; if (next_empty_ptr_rd_ack_o !== 1'b0) begin errors++; $display("FAIL init_exit_rd_ack got %0b want 0", next_empty_ptr_rd_ack_o); end
        tick();
        checks++; if (next_empty_ptr_rd_ack_o !== 1'b1) begin errors++; $display("FAIL idle_rd_ack got %0b want 1", next_empty_ptr_rd_ack_o); end
        checks++; if (alloc_val_o !== 1'b0) begin errors++; $display("FAIL idle_alloc_val got %0b want 0", alloc_val_o); end
        tick();
        alloc_req_i = 1'b0;
        checks++; if (alloc_val_o !== 1'b1) begin errors++; $display("FAIL first_grant_val got %0b want 1", alloc_val_o); end
        checks++; if (alloc_ptr_o !== 4'hA) begin errors++; $display("FAIL first_grant_ptr got %0h want a", alloc_ptr_o); end
        checks++; if (used_cnt_o !== 5'd1) begin errors++; $display("FAIL first_grant_used got %0d want 1", used_cnt_o); end
        tick();
        checks++; if (alloc_val_o !== 1'b0) begin errors++; $display("FAIL grant_one_cycle got %0b want 0", alloc_val_o); end
    endtask

    // Drain the whole pool, one grant every two cycles, then hit exhaustion.
    task automatic test_grant_stream();
        do_reset();
        next_empty_ptr_val_i = 1'b1;
        tick();
        alloc_req_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            next_empty_ptr_i = 4'(i);
            #1;
            checks++; if (next_empty_ptr_rd_ack_o !== 1'b1) begin errors++; $display("FAIL stream_rd_ack %0d got %0b want 1", i, next_empty_ptr_rd_ack_o); end
            tick();
            checks++; if (alloc_val_o !== 1'b1 || alloc_ptr_o !== 4'(i)) begin errors++; $display("FAIL stream_grant %0d got val %0b ptr %0h want 1 %0h", i, alloc_val_o, alloc_ptr_o, i); end
            checks++; if (next_empty_ptr_rd_ack_o !== 1'b0) begin errors++; $display("FAIL stream_grant_rd_ack %0d got %0b want 0", i, next_empty_ptr_rd_ack_o); end
            tick();
            checks++; if (alloc_val_o !== 1'b0) begin errors++; $display("FAIL stream_gap %0d got %0b want 0", i, alloc_val_o); end
        end
        next_empty_ptr_val_i = 1'b0;
        #1;
        checks++; if (next_empty_ptr_rd_ack_o !== 1'b0) begin errors++; $display("FAIL empty_rd_ack got %0b want 0", next_empty_ptr_rd_ack_o); end
        tick();
        alloc_req_i = 1'b0;
        checks++; if (alloc_fail_o !== 1'b1 || alloc_val_o !== 1'b0) begin errors++; $display("FAIL exhaust_fail got fail %0b val %0b want 1 0", alloc_fail_o, alloc_val_o); end
        checks++; if (used_cnt_o !== 5'd16) begin errors++; $display("FAIL exhaust_used got %0d want 16", used_cnt_o); end
        tick();
        checks++; if (alloc_fail_o !== 1'b0) begin errors++; $display("FAIL fail_one_cycle got %0b want 0", alloc_fail_o); end
    endtask

    // Grant and release in the same cycle, then a lone release.
    task automatic test_back_to_back();
        do_reset();
        next_empty_ptr_val_i = 1'b1;
        tick();
        alloc_req_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_empty_ptr_i = 4'(i);
            tick();
            tick();
        end
        checks++; if (used_cnt_o !== 5'd5) begin errors++; $display("FAIL b2b_used_pre got %0d want 5", used_cnt_o); end
        next_empty_ptr_i = 4'd5;
        free_ptr_i = 4'd2;
        free_en_i = 1'b1;
        #1;
        checks++; if (next_empty_ptr_rd_ack_o !== 1'b1 || free_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_handshake got ack %0b rdy %0b want 1 1", next_empty_ptr_rd_ack_o, free_ready_o); end
        tick();
        alloc_req_i = 1'b0;
        free_ptr_i = 4'd0;
        checks++; if (used_cnt_o !== 5'd5) begin errors++; $display("FAIL b2b_used_hold got %0d want 5", used_cnt_o); end
        checks++; if (alloc_val_o !== 1'b1 || alloc_ptr_o !== 4'd5) begin errors++; $display("FAIL b2b_grant got val %0b ptr %0h want 1 5", alloc_val_o, alloc_ptr_o); end
        checks++; if (add_empty_ptr_en_o !== 1'b1 || add_empty_ptr_o !== 4'd2) begin errors++; $display("FAIL b2b_push got en %0b ptr %0h want 1 2", add_empty_ptr_en_o, add_empty_ptr_o); end
        tick();
        free_en_i = 1'b0;
        checks++; if (used_cnt_o !== 5'd4) begin errors++; $display("FAIL release_used got %0d want 4", used_cnt_o); end
        checks++; if (add_empty_ptr_en_o !== 1'b1 || add_empty_ptr_o !== 4'd0) begin errors++; $display("FAIL release_push got en %0b ptr %0h want 1 0", add_empty_ptr_en_o, add_empty_ptr_o); end
        tick();
        checks++; if (add_empty_ptr_en_o !== 1'b0) begin errors++; $display("FAIL push_done got %0b want 0", add_empty_ptr_en_o); end
    endtask

`ifdef EMPTY_PTR_DBL_FREE_CHK_EN
    task automatic test_dbl_free();
        do_reset();
        next_empty_ptr_i = 4'd9;
        next_empty_ptr_val_i = 1'b1;
        tick();
        alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0;
        checks++; if (alloc_ptr_o !== 4'd9 || used_cnt_o !== 5'd1) begin errors++; $display("FAIL dbl_grant got ptr %0h used %0d want 9 1", alloc_ptr_o, used_cnt_o); end
        free_ptr_i = 4'd9;
        free_en_i = 1'b1;
        tick();
        checks++; if (used_cnt_o !== 5'd0 || dbl_free_o !== 1'b0) begin errors++; $display("FAIL dbl_first got used %0d dbl %0b want 0 0", used_cnt_o, dbl_free_o); end
        checks++; if (add_empty_ptr_en_o !== 1'b1 || add_empty_ptr_o !== 4'd9) begin errors++; $display("FAIL dbl_first_push got en %0b ptr %0h want 1 9", add_empty_ptr_en_o, add_empty_ptr_o); end
        tick();
        free_en_i = 1'b0;
        checks++; if (dbl_free_o !== 1'b1 || used_cnt_o !== 5'd0) begin errors++; $display("FAIL dbl_second got dbl %0b used %0d want 1 0", dbl_free_o, used_cnt_o); end
        checks++; if (add_empty_ptr_en_o !== 1'b0) begin errors++; $display("FAIL dbl_no_push got %0b want 0", add_empty_ptr_en_o); end
        tick();
        checks++; if (dbl_free_o !== 1'b0 || add_empty_ptr_en_o !== 1'b0) begin errors++; $display("FAIL dbl_quiet got dbl %0b en %0b want 0 0", dbl_free_o, add_empty_ptr_en_o); end
    endtask
`else
    // Six releases during INIT: four fill the buffer, two are dropped; drain starts after INIT.
    task automatic test_free_buffer();
        logic [3:0] exp_push [4];
        exp_push = '{4'd3, 4'd4, 4'd5, 4'd6};
        do_reset();
        free_en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            free_ptr_i = 4'(3 + i);
            #1;
            checks++; if (free_ready_o !== (i < 4)) begin errors++; $display("FAIL fill_ready %0d got %0b want %0b", i, free_ready_o, (i < 4)); end
            tick();
        end
        free_en_i = 1'b0;
        next_empty_ptr_val_i = 1'b1;
        #1;
        checks++; if (add_empty_ptr_en_o !== 1'b0) begin errors++; $display("FAIL init_no_drain got %0b want 0", add_empty_ptr_en_o); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (add_empty_ptr_en_o !== 1'b1 || add_empty_ptr_o !== exp_push[i]) begin errors++; $display("FAIL drain %0d got en %0b ptr %0h want 1 %0h", i, add_empty_ptr_en_o, add_empty_ptr_o, exp_push[i]); end
            tick();
        end
        checks++; if (add_empty_ptr_en_o !== 1'b0 || free_ready_o !== 1'b1) begin errors++; $display("FAIL drain_end got en %0b rdy %0b want 0 1", add_empty_ptr_en_o, free_ready_o); end
    endtask

    // Reset while the buffer holds two entries and a grant is on the outputs.
    task automatic test_reset_mid();
        do_reset();
        free_en_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            free_ptr_i = 4'(i);
            tick();
        end
        free_en_i = 1'b0;
        next_empty_ptr_i = 4'd7;
        next_empty_ptr_val_i = 1'b1;
        alloc_req_i = 1'b1;
        tick();
        checks++; if (add_empty_ptr_en_o !== 1'b1 || add_empty_ptr_o !== 4'd1) begin errors++; $display("FAIL mid_push1 got en %0b ptr %0h want 1 1", add_empty_ptr_en_o, add_empty_ptr_o); end
        tick();
        checks++; if (alloc_val_o !== 1'b1 || add_empty_ptr_o !== 4'd2) begin errors++; $display("FAIL mid_grant got val %0b ptr %0h want 1 2", alloc_val_o, add_empty_ptr_o); end
        rst_i = 1'b1;
        #1;
        checks++; if ({alloc_val_o, alloc_fail_o, add_empty_ptr_en_o, next_empty_ptr_rd_ack_o, free_ready_o} !== 5'b0) begin errors++; $display("FAIL mid_rst_strobes got %05b want 00000", {alloc_val_o, alloc_fail_o, add_empty_ptr_en_o, next_empty_ptr_rd_ack_o, free_ready_o}); end
        checks++; if (alloc_ptr_o !== 4'd0 || add_empty_ptr_o !== 4'd0 || used_cnt_o !== 5'd0) begin errors++; $display("FAIL mid_rst_values got ptr %0h add %0h used %0d want 0 0 0", alloc_ptr_o, add_empty_ptr_o, used_cnt_o); end
        alloc_req_i = 1'b0;
        next_empty_ptr_val_i = 1'b0;
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if (free_ready_o !== 1'b1 || add_empty_ptr_en_o !== 1'b0) begin errors++; $display("FAIL mid_rel got rdy %0b en %0b want 1 0", free_ready_o, add_empty_ptr_en_o); end
        tick();
        checks++; if (alloc_val_o !== 1'b0 || add_empty_ptr_en_o !== 1'b0) begin errors++; $display("FAIL mid_after got val %0b en %0b want 0 0", alloc_val_o, add_empty_ptr_en_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_init_hold();
        test_grant_stream();
        test_back_to_back();
`ifdef EMPTY_PTR_DBL_FREE_CHK_EN
        test_dbl_free();
`else
        test_free_buffer();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
